// File: rtl/sr_bank_pkg.sv
// Shared definitions for the SR flip-flop bank writer.
package sr_bank_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_e;

endpackage

// File: rtl/sr_excite.sv
// Per-bit SR excitation table: set where target is 1 and current is 0, reset where
// target is 0 and current is 1, both gated by enable. S and R are mutually exclusive.
module sr_excite
    import sr_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] tgt,
    input  logic [WIDTH-1:0] en,
    output logic [WIDTH-1:0] s_c,
    output logic [WIDTH-1:0] r_c
);

    // Excitation: 00 hold, 10 set, 01 clear; 11 is never produced.
    always_comb begin
        s_c = tgt & ~cur & en;
        r_c = ~tgt & cur & en;
    end

endmodule

// File: rtl/sr_bank_writer.sv
// Writes masked data into an external SR flip-flop bank with a one-cycle S/R pulse,
// then reads the bank back and records mismatching bits in sticky error flags.
module sr_bank_writer
    import sr_bank_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic [WIDTH-1:0] S,
    output logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] Q_fb,
    input  logic             clr_err,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    state_e           state_q, state_d;
    logic             wr_ready_q, wr_ready_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    logic             accept_c;
    logic [WIDTH-1:0] req_tgt_c;
    logic [WIDTH-1:0] exc_s_c, exc_r_c;
    logic [WIDTH-1:0] mis_c;

    // Request handshake and the target value a request would produce.
    always_comb begin
        accept_c  = (state_q == IDLE) && wr_ready_q && wr_valid;
        req_tgt_c = (Q_fb & ~wr_mask) | (wr_data & wr_mask);
        mis_c     = (Q_fb ^ tgt_q) & mask_q;
    end

    // Excitation for the request being accepted; registered into the DRIVE pulse.
    sr_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .cur (Q_fb),
        .tgt (req_tgt_c),
        .en  (wr_mask),
        .s_c (exc_s_c),
        .r_c (exc_r_c)
    );

    // State register.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: IDLE waits for a request, DRIVE and CHECK last one cycle each.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept_c) state_d = DRIVE;
            DRIVE:   state_d = CHECK;
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: request capture, S/R pulse, ready, sticky errors.
    always_comb begin
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        mask_d     = mask_q;
        s_d        = '0;
        r_d        = '0;
        wr_ready_d = (state_d == IDLE);
        err_d      = err_q;
        err_bits_d = err_bits_q;

        if (accept_c) begin
            cur_d  = Q_fb;
            tgt_d  = req_tgt_c;
            mask_d = wr_mask;
            s_d    = exc_s_c;
            r_d    = exc_r_c;
        end

        // A mismatch seen on the CHECK exit edge wins over a simultaneous clear.
        if ((state_q == CHECK) && (mis_c != '0)) begin
            err_d      = 1'b1;
            err_bits_d = clr_err ? mis_c : (err_bits_q | mis_c);
        end else if (clr_err) begin
            err_d      = 1'b0;
            err_bits_d = '0;
        end
    end

    // Datapath and output registers; reset kills any in-flight pulse at once.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            cur_q      <= '0;
            tgt_q      <= '0;
            mask_q     <= '0;
            s_q        <= '0;
            r_q        <= '0;
            wr_ready_q <= 1'b0;
            err_q      <= 1'b0;
            err_bits_q <= '0;
        end else begin
            cur_q      <= cur_d;
            tgt_q      <= tgt_d;
            mask_q     <= mask_d;
            s_q        <= s_d;
            r_q        <= r_d;
            wr_ready_q <= wr_ready_d;
            err_q      <= err_d;
            err_bits_q <= err_bits_d;
        end
    end

    // The captured current value is kept for debug visibility of the last request.
    logic unused_cur_c;
    always_comb unused_cur_c = ^cur_q;

    // Registered outputs.
    always_comb begin
        wr_ready = wr_ready_q;
        S        = s_q;
        R        = r_q;
        err      = err_q;
        err_bits = err_bits_q;
    end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Bench for sr_bank_writer driving a modelled 8-bit SR flip-flop bank.
module tb_sr_bank_writer;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] wr_mask = 8'h00;
    logic [7:0] S;
    logic [7:0] R;
    logic [7:0] bank_q = 8'h00;
    logic [7:0] stuck = 8'h00;
    logic       clr_err = 1'b0;
    logic       err;
    logic [7:0] err_bits;

    int n_checks = 0;
    int n_fail   = 0;

    logic       tb_err = 1'b0;
    logic [7:0] tb_err_bits = 8'h00;

    typedef struct {
        logic [7:0] exp_s;
        logic [7:0] exp_r;
        logic [7:0] exp_q;
        logic [7:0] exp_mis;
        bit         clr;
    } sb_item_t;

    sb_item_t sb_q[$];

    sr_bank_writer #(.WIDTH(8)) dut (
        .clk      (clk),
        .RST      (RST),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .S        (S),
        .R        (R),
        .Q_fb     (bank_q),
        .clr_err  (clr_err),
        .err      (err),
        .err_bits (err_bits)
    );

    always #5 clk = ~clk;

    // SR bank: synchronous capture; 00 hold, 01 clear, 10 set; stuck bits forced to 0.
    always @(posedge clk) begin
        logic [7:0] nxt;
        for (int i = 0; i < 8; i++) begin
            case ({S[i], R[i]})
                2'b10:   nxt[i] = 1'b1;
                2'b01:   nxt[i] = 1'b0;
                default: nxt[i] = bank_q[i];
            endcase
        end
        bank_q <= nxt & ~stuck;
    end

    task automatic test_reset();
        n_checks++;
        if (wr_ready !== 1'b0 || S !== 8'h00 || R !== 8'h00 || err !== 1'b0 || err_bits !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b S=%h R=%h err=%b bits=%h, required 0 0 0 0 0",
                     wr_ready, S, R, err, err_bits);
        end
        @(negedge clk);
        RST = 1'b1;
        #1;
        n_checks++;
        if (wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 0", wr_ready);
        end
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b required 1", wr_ready);
        end
    endtask

    // One write with hand-derived expectations; busy-time inputs are junk to be ignored.
    task automatic do_write(input string name, input logic [7:0] data, input logic [7:0] mask,
                            input logic [7:0] exp_s, input logic [7:0] exp_r,
                            input logic [7:0] exp_q, input logic [7:0] exp_mis, input bit clr);
        sb_item_t it;
        int waited = 0;
        while (wr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (wr_ready !== 1'b1 || S !== 8'h00 || R !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_idle: rdy=%b S=%h R=%h required 1 00 00", name, wr_ready, S, R);
        end
        wr_valid = 1'b1;
        wr_data  = data;
        wr_mask  = mask;
        sb_q.push_back('{exp_s, exp_r, exp_q, exp_mis, clr});
        @(negedge clk);
        wr_data = ~data;
        wr_mask = 8'hFF;
        n_checks++;
        if (S !== exp_s || R !== exp_r || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drive: S=%h R=%h rdy=%b required %h %h 0", name, S, R, wr_ready, exp_s, exp_r);
        end
        @(negedge clk);
        n_checks++;
        if (S !== 8'h00 || R !== 8'h00 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_check: S=%h R=%h rdy=%b required 00 00 0", name, S, R, wr_ready);
        end
        clr_err = clr;
        @(negedge clk);
        clr_err  = 1'b0;
        wr_valid = 1'b0;
        it = sb_q.pop_front();
        if (it.clr) begin
            tb_err      = (it.exp_mis != 8'h00);
            tb_err_bits = it.exp_mis;
        end else if (it.exp_mis != 8'h00) begin
            tb_err      = 1'b1;
            tb_err_bits = tb_err_bits | it.exp_mis;
        end
        n_checks++;
        if (wr_ready !== 1'b1 || bank_q !== it.exp_q) begin
            n_fail++;
            $display("FAIL %s_done: rdy=%b Q=%h required 1 %h", name, wr_ready, bank_q, it.exp_q);
        end
        n_checks++;
        if (err !== tb_err || err_bits !== tb_err_bits) begin
            n_fail++;
            $display("FAIL %s_err: err=%b bits=%h required %b %h", name, err, err_bits, tb_err, tb_err_bits);
        end
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err     = 1'b0;
        tb_err      = 1'b0;
        tb_err_bits = 8'h00;
        n_checks++;
        if (err !== 1'b0 || err_bits !== 8'h00) begin
            n_fail++;
            $display("FAIL clr_err: err=%b bits=%h required 0 00", err, err_bits);
        end
    endtask

    task automatic test_basic();
        do_write("wr_a5", 8'hA5, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b0);
        do_write("wr_0f_f0", 8'h0F, 8'hF0, 8'h00, 8'hA0, 8'h05, 8'h00, 1'b0);
        do_write("mask0", 8'hFF, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 1'b0);
    endtask

    task automatic test_stuck();
        stuck = 8'h04;
        do_write("stuck", 8'h04, 8'h04, 8'h00, 8'h00, 8'h01, 8'h04, 1'b0);
        stuck = 8'h00;
        do_write("clean", 8'h80, 8'h80, 8'h80, 8'h00, 8'h81, 8'h00, 1'b0);
        pulse_clr();
    endtask

    task automatic test_clr_collision();
        stuck = 8'h04;
        do_write("clr_mis", 8'h04, 8'h04, 8'h04, 8'h00, 8'h81, 8'h04, 1'b1);
        stuck = 8'h00;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_collision: err=%b required 1", err);
        end
        pulse_clr();
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        wr_mask  = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ((S & R) !== 8'h00) begin
                n_fail++;
                $display("FAIL sr_overlap_%0d: S&R=%h required 00", i, S & R);
            end
            if (wr_ready === 1'b1) accepts++;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((S & R) !== 8'h00) begin
                n_fail++;
                $display("FAIL sr_overlap_tail_%0d: S&R=%h required 00", i, S & R);
            end
            @(negedge clk);
        end
        n_checks++;
        if (accepts != 4) begin
            n_fail++;
            $display("FAIL b2b_accepts: got %0d required 4", accepts);
        end
        n_checks++;
        if (bank_q !== 8'h3C || wr_ready !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_final: Q=%h rdy=%b err=%b required 3c 1 0", bank_q, wr_ready, err);
        end
    endtask

    task automatic test_mid_reset();
        wr_valid = 1'b1;
        wr_data  = 8'hFF;
        wr_mask  = 8'hFF;
        @(negedge clk);
        wr_valid = 1'b0;
        n_checks++;
        if (S !== 8'hC3 || R !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_pre_drive: S=%h R=%h required c3 00", S, R);
        end
        #2;
        RST = 1'b0;
        #1;
        n_checks++;
        if (S !== 8'h00 || R !== 8'h00 || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_async: S=%h R=%h rdy=%b required 00 00 0", S, R, wr_ready);
        end
        @(negedge clk);
        RST = 1'b1;
        #1;
        n_checks++;
        if (bank_q !== 8'h3C || wr_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_release: Q=%h rdy=%b required 3c 0", bank_q, wr_ready);
        end
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 1'b1 || bank_q !== 8'h3C || S !== 8'h00 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_recover: rdy=%b Q=%h S=%h err=%b required 1 3c 00 0", wr_ready, bank_q, S, err);
        end
    endtask

    initial begin
        #5;
        test_reset();
        test_basic();
        test_stuck();
        test_clr_collision();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
